// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared types and constants for the gated frequency meter.
//   state_t     - measurement FSM states (IDLE, MEAS, DONE)
//   SYNC_STAGES - depth of the input synchronizer in sync_edge
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/freq_meter_if.sv
// freq_meter_if: result/control handshake of the frequency meter.
//   start - begin one measurement (single-shot mode)
//   ack   - consumer accepts the presented result
//   count - rising-edge count of the last completed window (CW bits)
//   ovf   - count saturated during that window
//   valid - count/ovf hold an unaccepted result
//   busy  - a gate window is in progress
//   miss  - a result was overwritten before ack (continuous mode)
// master: consumer side, slave: meter side.
interface freq_meter_if #(
  parameter int CW = 8
);
  logic          start;
  logic          ack;
  logic [CW-1:0] count;
  logic          ovf;
  logic          valid;
  logic          busy;
  logic          miss;

  modport master (output start, ack, input count, ovf, valid, busy, miss);
  modport slave  (input start, ack, output count, ovf, valid, busy, miss);
endinterface

// File: rtl/freq_meter_sync_edge.sv
// sync_edge: synchronizes an asynchronous level into the fin domain and
// emits a registered one-cycle pulse on each rising edge.
//   fin  - destination clock
//   rst  - asynchronous active-high reset
//   d    - asynchronous input level
//   rise - one-cycle pulse, 3 fin edges after d rises
module sync_edge
  import freq_meter_pkg::*;
(
  input  logic fin,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_rise;

  always_ff @(posedge fin or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
      r_hist <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_hist;
    end
  end

  assign rise = r_rise;
endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous signal over a gate
// window of GATE fin cycles and presents the count on a valid/ack handshake.
//   fin - reference clock, rst - async active-high reset
//   sig - asynchronous signal to measure
//   bus - freq_meter_if slave (start/ack in; count/ovf/valid/busy/miss out)
// Macro FREQ_METER_CONT_EN: continuous back-to-back windows with miss
// detection; undefined gives single-shot start/ack operation, miss tied 0.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE = 256,
  parameter int CW   = 8
) (
  input  logic         fin,
  input  logic         rst,
  input  logic         sig,
  freq_meter_if.slave  bus
);
  localparam int            GW        = $clog2(GATE);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE - 1);
  localparam logic [CW-1:0] ACC_MAX   = '1;

  state_t        r_state, w_state_nxt;
  logic [GW-1:0] r_gate;
  logic [CW-1:0] r_acc, w_acc_nxt;
  logic          r_ovf_acc, w_ovf_nxt;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_valid;
  logic          w_edge;
  logic          w_clr;   // entering MEAS: restart gate and accumulator
  logic          w_end;   // last cycle of the gate window

  sync_edge u_sync (
    .fin  (fin),
    .rst  (rst),
    .d    (sig),
    .rise (w_edge)
  );

  always_ff @(posedge fin or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      IDLE: begin
`ifdef FREQ_METER_CONT_EN
        w_state_nxt = MEAS;
        w_clr       = 1'b1;
`else
        if (bus.start) begin
          w_state_nxt = MEAS;
          w_clr       = 1'b1;
        end
`endif
      end
      MEAS: begin
        if (r_gate == GATE_LAST) begin
          w_end = 1'b1;
`ifdef FREQ_METER_CONT_EN
          w_state_nxt = MEAS;
`else
          w_state_nxt = DONE;
`endif
        end
      end
      DONE: if (bus.ack) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Edge in the current cycle is folded in, including the window's last cycle.
  // Overflow means an edge arrived with the accumulator already saturated.
  always_comb begin
    w_acc_nxt = r_acc;
    w_ovf_nxt = r_ovf_acc;
    if (w_edge) begin
      if (r_acc == ACC_MAX) w_ovf_nxt = 1'b1;
      else                  w_acc_nxt = r_acc + CW'(1);
    end
  end

  always_ff @(posedge fin or posedge rst) begin
    if (rst) begin
      r_gate    <= '0;
      r_acc     <= '0;
      r_ovf_acc <= 1'b0;
    end else if (w_clr || w_end) begin
      r_gate    <= '0;
      r_acc     <= '0;
      r_ovf_acc <= 1'b0;
    end else if (r_state == MEAS) begin
      r_gate    <= r_gate + GW'(1);
      r_acc     <= w_acc_nxt;
      r_ovf_acc <= w_ovf_nxt;
    end
  end

`ifdef FREQ_METER_CONT_EN
  logic r_miss;

  // Window end beats a simultaneous ack; an ack in that cycle still
  // counts as the consumer having taken the old result, so no miss.
  always_ff @(posedge fin or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_miss  <= 1'b0;
    end else if (w_end) begin
      r_count <= w_acc_nxt;
      r_ovf   <= w_ovf_nxt;
      r_valid <= 1'b1;
      r_miss  <= bus.ack ? 1'b0 : (r_miss | r_valid);
    end else if (bus.ack) begin
      r_valid <= 1'b0;
      r_miss  <= 1'b0;
    end
  end

  assign bus.miss = r_miss;
`else
  always_ff @(posedge fin or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_end) begin
      r_count <= w_acc_nxt;
      r_ovf   <= w_ovf_nxt;
      r_valid <= 1'b1;
    end else if (r_state == DONE && bus.ack) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.miss = 1'b0;
`endif

  assign bus.count = r_count;
  assign bus.ovf   = r_ovf;
  assign bus.valid = r_valid;
  assign bus.busy  = (r_state == MEAS);
endmodule

// File: doc/freq_meter.md
# freq_meter

Gated edge-counting frequency meter that consumes the divided clock produced by the clock-divider stage. It samples that output as an asynchronous signal in the `fin` domain and counts its rising edges over a fixed gate window of `fin` cycles. It presents the result on a valid/ack handshake. It is used for on-chip divider self-check and ratio measurement.

## Interface
- `GATE`, default 256: gate window length in `fin` cycles; must be ≥ 2.
- `CW`, default 8: result width in bits.
- `fin`, in, 1: reference clock; all state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: starts one measurement; single-shot mode only.
- `sig`, in, 1: asynchronous signal to measure, e.g. the divider output.
- `ack`, in, 1: consumer accepts the result.
- `count`, out, `CW`: rising-edge count of the last completed window.
- `ovf`, out, 1: the count saturated during the window.
- `valid`, out, 1: `count` and `ovf` hold an unaccepted result.
- `busy`, out, 1: a window is in progress.
- `miss`, out, 1: a result was overwritten before it was acked; continuous mode only, tied 0 otherwise.

## Operation
- **Input path:** `sig` → 2-flop synchronizer → registered rising-edge detect. This produces a 1-cycle `edge_p` per `sig` rising edge.
- **States:** IDLE, MEAS, DONE.
  - IDLE: `start`=1 → MEAS. Entering MEAS clears the gate counter and the edge accumulator.
  - MEAS: the gate counter increments every cycle.
    - Each `edge_p` increments the accumulator.
    - The accumulator saturates at 2^CW−1 and sets an internal overflow bit.
    - In the cycle where the gate counter == GATE−1 (including any `edge_p` in that cycle), accumulator and overflow load into `count`/`ovf`, `valid` sets, and the state moves to DONE.
  - DONE: `ack`=1 → IDLE and `valid` clears. `start` is ignored in DONE and MEAS.
- **Result stability:** `count`/`ovf` change only when a window completes.
- **Simultaneous events:**
  - `ack` and window completion in the same cycle (continuous mode): the new result wins and `valid` stays 1.
  - `start`=1 in the same cycle as entering IDLE: no effect.
- **Reset:**
  - Reset value of every output is 0: `count`, `ovf`, `valid`, `busy`, `miss`.
  - Reset places the FSM in IDLE and clears the synchronizer flops, gate counter and accumulator.
  - A reset mid-window discards the partial count.
- **Width:** the gate counter is `$clog2(GATE)` bits; the accumulator is `CW` bits.

## Timing
- Latency from a `sig` rising edge to `edge_p` is 3 `fin` edges: 2 sync flops plus the edge register.
- `busy`=1 from the cycle after `start` is sampled, for exactly GATE cycles.
- `valid` rises on the same edge that `busy` falls.
- `valid` falls on the first `fin` edge that samples `ack`=1.
- `sig` high and low phases must each be ≥ 2 `fin` periods for exact counts.
- Back-to-back windows (continuous mode) have zero dead cycles.

## Configuration
- **`FREQ_METER_CONT_EN` defined (continuous mode):**
  - After reset the FSM enters MEAS directly and loops MEAS→MEAS forever; DONE is unused.
  - `start` is ignored.
  - `valid` is a separate flag: set at each window end, cleared by `ack`.
  - If a window ends while `valid`=1 and `ack`=0, the result is overwritten and `miss` sets.
  - `miss` is sticky and clears together with `valid` on `ack`.
- **Undefined (single-shot mode):** the IDLE/MEAS/DONE behaviour above applies and `miss` is constant 0.

## Structure
- **`freq_meter_pkg`:** the state enum (IDLE, MEAS, DONE) and the synchronizer depth constant `SYNC_STAGES = 2`.
- **Sub-module `sync_edge`:** synchronizer plus rising-edge detector, with ports `fin`, `rst`, `d`, `rise`. It is reused elsewhere for async strobes.

## Test plan
- **Single shot:** GATE=16, CW=8, `sig` period 4 `fin` cycles; pulse `start` → `busy` high 16 cycles, then `valid`=1, `count`=4, `ovf`=0.
- **Overflow:** GATE=64, CW=3, `sig` period 4 → `count`=7, `ovf`=1.
- **Handshake hold:** hold `ack`=0 for 10 cycles after `valid` → `count` stable and `valid`=1 throughout. Pulse `ack` → `valid`=0 next edge and FSM in IDLE. A `start` pulse during DONE is ignored.
- **Reset mid-window:** assert `rst` at gate cycle 8 → all outputs 0 immediately. A new `start` then yields `count`=4 (same stimulus as the single-shot case).
- **Continuous mode:** `FREQ_METER_CONT_EN`, GATE=16, `sig` period 8; no `ack` for two windows → `count`=2, `valid`=1, `miss`=1. Then `ack` → `valid`=0 and `miss`=0.
- **Divider chain:** drive `sig` from the divider with Ndiv=2 (fout period 6 `fin`), GATE=48 → `count`=8.
